bist_golden_recorder: RTL and testbench

- Write-side counterpart of the BIST response comparator. It generates the same LFSR stimulus pair (A, B) used by the BIST, drives it into a known-good ALU, and captures each 9-bit response {ALU_Out, CarryOut} into an internal golden-response memory at sequential addresses.
- Afterwards it streams the captured table out over a valid/ready port. The bench writes that stream to the .mem file that the BIST golden ROM loads.
- Entry k in the memory pairs with BIST address k.

---
 rtl/bist_golden_recorder.sv | 113 +++++++++++
 tb/tb_bist_golden_recorder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_golden_recorder.sv
// Captures the known-good ALU response to the BIST LFSR stimulus sequence into a golden table,
// then streams that table out over a valid/ready port. state_dbg encoding: 0 IDLE, 1 CAPTURE, 2 DONE, 3 DUMP.
module bist_golden_recorder #(
  parameter int          DEPTH  = 256,
  parameter int          AW     = 8,
  parameter logic [7:0]  SEED_A = 8'h02,
  parameter logic [7:0]  SEED_B = 8'h01
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [8:0]    resp,
  output logic [7:0]    A,
  output logic [7:0]    B,
  output logic          busy,
  output logic          done,
  input  logic          dump_req,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [8:0]    out_data,
  output logic [AW-1:0] out_addr,
  output logic [1:0]    state_dbg
);

  // Dump port: a transfer happens on any rising edge where out_valid && out_ready are both high.
  // out_valid depends only on the state, never combinationally on out_ready; data and address
  // hold stable while the sink stalls.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2,
    DUMP    = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] cnt;
  logic [AW-1:0] rd_ptr;
  logic [8:0]    mem [DEPTH];

  function automatic logic [7:0] lfsr_step(input logic [7:0] r);
    return {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      A      <= SEED_A;
      B      <= SEED_B;
      cnt    <= '0;
      rd_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= CAPTURE;
            cnt   <= '0;
          end
        end
        CAPTURE: begin
          // The final capture edge reloads the seeds so the next run restarts the same sequence.
          if (cnt == LAST) begin
            state <= DONE;
            cnt   <= '0;
            A     <= SEED_A;
            B     <= SEED_B;
          end else begin
            cnt <= cnt + 1'b1;
            A   <= lfsr_step(A);
            B   <= lfsr_step(B);
          end
        end
        DONE: begin
          if (start) begin
            state <= CAPTURE;
            cnt   <= '0;
          end else if (dump_req) begin
            state  <= DUMP;
            rd_ptr <= '0;
          end
        end
        DUMP: begin
          if (out_ready) begin
            if (rd_ptr == LAST) begin
              state  <= DONE;
              rd_ptr <= '0;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Table storage is deliberately left out of reset; a run always rewrites every entry.
  always_ff @(posedge clk) begin
    if (state == CAPTURE) begin
      mem[cnt] <= resp;
    end
  end

  assign busy      = (state == CAPTURE) || (state == DUMP);
  assign done      = (state == DONE);
  assign out_valid = (state == DUMP);
  assign out_data  = (state == DUMP) ? mem[rd_ptr] : 9'h000;
  assign out_addr  = rd_ptr;
  assign state_dbg = state;

endmodule

// File: tb/tb_bist_golden_recorder.sv
// Directed bench for bist_golden_recorder: an ADD (or forced-carry) ALU model feeds the recorder and
// every dumped entry is compared to a table built from the LFSR rule and plain addition.
module tb_bist_golden_recorder;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [8:0]    resp;
  logic [7:0]    A, B;
  logic          busy, done;
  logic          dump_req;
  logic          out_valid, out_ready;
  logic [8:0]    out_data;
  logic [AW-1:0] out_addr;
  logic [1:0]    state_dbg;

  bist_golden_recorder #(.DEPTH(DEPTH), .AW(AW), .SEED_A(8'h02), .SEED_B(8'h01)) dut (
    .clk(clk), .reset(reset), .start(start), .resp(resp), .A(A), .B(B),
    .busy(busy), .done(done), .dump_req(dump_req), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // ALU under capture: 8-bit add, carry in the LSB position
  logic       force_carry;
  logic [8:0] sum9;
  assign sum9 = {1'b0, A} + {1'b0, B};
  assign resp = force_carry ? 9'h1FF : {sum9[7:0], sum9[8]};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: expected golden table
  logic [8:0] exp_tab [DEPTH];
  logic [8:0] dump_log [DEPTH];
  int exp_idx  = 0;
  int xfer_cnt = 0;

  function automatic logic [7:0] lfsr_next(input logic [7:0] r);
    return {r[6:0], ^(r & 8'hB8)};
  endfunction

  task automatic build_table(input bit carry_mode);
    logic [7:0] a, b;
    logic [8:0] s;
    a = 8'h02;
    b = 8'h01;
    for (int k = 0; k < DEPTH; k++) begin
      s = {1'b0, a} + {1'b0, b};
      exp_tab[k] = carry_mode ? 9'h1FF : {s[7:0], s[8]};
      a = lfsr_next(a);
      b = lfsr_next(b);
    end
  endtask

  // scoreboard compare process: every cycle the dump port is valid
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_idx >= DEPTH) begin
        check("unexpected_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        check("dump_addr", {29'b0, out_addr}, exp_idx);
        check("dump_data", {23'b0, out_data}, {23'b0, exp_tab[exp_idx]});
        dump_log[exp_idx] = out_data;
        if (out_ready) begin
          exp_idx++;
          xfer_cnt++;
        end
      end
    end
  end

  // driver tasks
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    bit vseen;
    n = 0;
    vseen = 0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (out_valid) vseen = 1;
    end
    check("done_reached", {31'b0, done}, 32'd1);
    check("no_valid_in_capture", {31'b0, vseen}, 32'd0);
  endtask

  task automatic do_dump(input bit stall);
    int n;
    bit stalled;
    exp_idx  = 0;
    xfer_cnt = 0;
    stalled  = 0;
    out_ready = 1'b1;
    dump_req  = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    check("dump_enter_valid", {31'b0, out_valid}, 32'd1);
    check("dump_enter_busy", {31'b0, busy}, 32'd1);
    n = 0;
    while (!done && n < 100) begin
      if (stall && !stalled && out_addr == 3'd1) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_valid", {31'b0, out_valid}, 32'd1);
          check("stall_data", {23'b0, out_data}, 32'h00C);
          check("stall_addr", {29'b0, out_addr}, 32'd1);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
        stalled = 1;
      end
      @(posedge clk); #1;
      n++;
    end
    check("dump_done", {31'b0, done}, 32'd1);
    check("dump_xfers", xfer_cnt, DEPTH);
    check("dump_valid_dropped", {31'b0, out_valid}, 32'd0);
    if (stall) check("stall_happened", {31'b0, stalled}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    dump_req = 1'b0;
    out_ready = 1'b0;
    force_carry = 1'b0;
    build_table(1'b0);
    // hand-computed pins for the model: 02+01, 04+02, 08+04, 11+08
    check("model_e0", {23'b0, exp_tab[0]}, 32'h006);
    check("model_e1", {23'b0, exp_tab[1]}, 32'h00C);
    check("model_e2", {23'b0, exp_tab[2]}, 32'h018);
    check("model_e3", {23'b0, exp_tab[3]}, 32'h032);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_A", {24'b0, A}, 32'h02);
    check("rst_B", {24'b0, B}, 32'h01);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_data", {23'b0, out_data}, 32'h0);
    check("rst_addr", {29'b0, out_addr}, 32'h0);
    check("rst_state", {30'b0, state_dbg}, 32'd0);

    // dump_req in IDLE is ignored
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    check("idle_dump_ignored", {31'b0, out_valid}, 32'd0);

    // completion timing, with a stray start pulse mid-capture
    do_start();
    check("t_busy_e0", {31'b0, busy}, 32'd1);
    check("t_A_e0", {24'b0, A}, 32'h02);
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      check("t_done", {31'b0, done}, (k == DEPTH) ? 32'd1 : 32'd0);
      check("t_busy", {31'b0, busy}, (k == DEPTH) ? 32'd0 : 32'd1);
      if (k == 1) begin
        check("t_A_e1", {24'b0, A}, 32'h04);
        check("t_B_e1", {24'b0, B}, 32'h02);
      end
      if (k == 3) start = 1'b1;
    end
    check("t_A_reseed", {24'b0, A}, 32'h02);
    check("t_B_reseed", {24'b0, B}, 32'h01);

    // sequence check
    do_dump(1'b0);
    check("seq_e0", {23'b0, dump_log[0]}, 32'h006);
    check("seq_e1", {23'b0, dump_log[1]}, 32'h00C);
    check("seq_e2", {23'b0, dump_log[2]}, 32'h018);
    check("seq_e3", {23'b0, dump_log[3]}, 32'h032);

    // backpressure
    do_dump(1'b1);

    // simultaneous start and dump_req in DONE: start wins
    start = 1'b1;
    dump_req = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dump_req = 1'b0;
    check("sim_busy", {31'b0, busy}, 32'd1);
    check("sim_done", {31'b0, done}, 32'd0);
    check("sim_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    wait_done(20);

    // carry capture
    force_carry = 1'b1;
    do_start();
    wait_done(20);
    force_carry = 1'b0;
    build_table(1'b1);
    do_dump(1'b0);

    // reset mid-capture, then a clean run
    do_start();
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_busy", {31'b0, busy}, 32'd0);
    check("mid_done", {31'b0, done}, 32'd0);
    check("mid_A", {24'b0, A}, 32'h02);
    check("mid_B", {24'b0, B}, 32'h01);
    check("mid_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    build_table(1'b0);
    do_start();
    wait_done(20);
    do_dump(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
